aec_sched: RTL and testbench

- Round-robin scheduler that shares one arithmetic-expression-calculator (AEC) instance among NREQ requesters.
- The granted requester streams one ASCII expression into a local buffer, terminated by '='.
- The scheduler bursts the buffered expression to the AEC on consecutive cycles, waits for the AEC result, and returns it tagged with the requester ID.
- It guards against over-length expressions and a hung AEC.

---
 rtl/aec_sched.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_aec_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aec_sched.sv
// Round-robin scheduler sharing one AEC among NREQ requesters: buffer, burst, wait, respond.
// Define AEC_SCHED_STATS_EN to add saturating response counters stat_done / stat_err.
module aec_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic [7:0]      in_char,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      aec_ascii,
  output logic            aec_ready,
  input  logic            aec_valid,
  input  logic [6:0]      aec_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IDW-1:0]  resp_id,
  output logic [6:0]      resp_result,
  output logic [1:0]      resp_err,
  output logic            busy
`ifdef AEC_SCHED_STATS_EN
  ,
  output logic [15:0]     stat_done,
  output logic [15:0]     stat_err
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_SEND, S_WAIT, S_RESP, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            in_ready_q, in_ready_d;
  logic [7:0]      aec_ascii_q, aec_ascii_d;
  logic            aec_ready_q, aec_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [6:0]      resp_result_q, resp_result_d;
  logic [1:0]      resp_err_q, resp_err_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   send_idx_q, send_idx_d;
  logic            ovf_q, ovf_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [7:0]      buf_q [MAX_LEN];

  logic            arb_found;
  logic [IDW-1:0]  arb_idx;
  logic            last_ovf;
  logic            buf_we;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign wr_idx = cnt_q[AW-1:0];
  assign rd_idx = send_idx_q[AW-1:0];

  // Round-robin pick: first set req at or above rr_q, else first set req from 0.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_found && req[k] && (k >= int'(rr_q))) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(k);
      end else begin
        arb_found = arb_found;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_found && req[k]) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(k);
      end else begin
        arb_found = arb_found;
      end
    end
  end

  // Next-state and next-output logic for the whole scheduler.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    in_ready_d    = in_ready_q;
    aec_ascii_d   = aec_ascii_q;
    aec_ready_d   = aec_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    cnt_d         = cnt_q;
    send_idx_d    = send_idx_q;
    ovf_d         = ovf_q;
    timer_d       = timer_q;
    rr_d          = rr_q;
    buf_we        = 1'b0;
    last_ovf      = ovf_q || (cnt_q == CW'(MAX_LEN));
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
        else      state_d = S_IDLE;
      end
      S_ARB: begin
        if (arb_found) begin
          state_d    = S_LOAD;
          gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
          in_ready_d = 1'b1;
          resp_id_d  = arb_idx;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          if (arb_idx == IDW'(NREQ - 1)) rr_d = '0;
          else                           rr_d = arb_idx + 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          if (in_char == 8'h3D) begin
            in_ready_d = 1'b0;
            if (last_ovf) begin
              state_d       = S_RESP;
              resp_valid_d  = 1'b1;
              resp_err_d    = 2'd1;
              resp_result_d = 7'd0;
            end else begin
              buf_we      = 1'b1;
              cnt_d       = cnt_q + 1'b1;
              state_d     = S_SEND;
              aec_ready_d = 1'b1;
              // The first character may be the '=' being written on this very edge.
              aec_ascii_d = (cnt_q == '0) ? in_char : buf_q[0];
              send_idx_d  = CW'(1);
            end
          end else if (last_ovf) begin
            ovf_d = 1'b1;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end else begin
          ovf_d = ovf_q;
        end
      end
      S_SEND: begin
        if (send_idx_q == cnt_q) begin
          state_d     = S_WAIT;
          aec_ready_d = 1'b0;
          aec_ascii_d = 8'h00;
          timer_d     = '0;
        end else begin
          aec_ascii_d = buf_q[rd_idx];
          send_idx_d  = send_idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (aec_valid) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_result_d = aec_result;
          resp_err_d    = 2'd0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_result_d = 7'd0;
          resp_err_d    = 2'd2;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_GAP;
          resp_valid_d = 1'b0;
          gnt_d        = '0;
          cnt_d        = '0;
          ovf_d        = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      S_GAP: begin
        if (|req) state_d = S_ARB;
        else      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      in_ready_q    <= 1'b0;
      aec_ascii_q   <= 8'h00;
      aec_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= 7'd0;
      resp_err_q    <= 2'd0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      send_idx_q    <= '0;
      ovf_q         <= 1'b0;
      timer_q       <= '0;
      rr_q          <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      in_ready_q    <= in_ready_d;
      aec_ascii_q   <= aec_ascii_d;
      aec_ready_q   <= aec_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      send_idx_q    <= send_idx_d;
      ovf_q         <= ovf_d;
      timer_q       <= timer_d;
      rr_q          <= rr_d;
    end
  end

  // Expression buffer; contents are only meaningful below cnt_q.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_idx] <= in_char;
  end

  assign gnt         = gnt_q;
  assign in_ready    = in_ready_q;
  assign aec_ascii   = aec_ascii_q;
  assign aec_ready   = aec_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;

`ifdef AEC_SCHED_STATS_EN
  logic [15:0] stat_done_q, stat_done_d;
  logic [15:0] stat_err_q, stat_err_d;

  // Saturating counters bumped on the response handshake.
  always_comb begin
    stat_done_d = stat_done_q;
    stat_err_d  = stat_err_q;
    if (resp_valid_q && resp_ready) begin
      if (resp_err_q == 2'd0) begin
        if (stat_done_q != 16'hFFFF) stat_done_d = stat_done_q + 16'd1;
        else                         stat_done_d = stat_done_q;
      end else begin
        if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
        else                        stat_err_d = stat_err_q;
      end
    end else begin
      stat_done_d = stat_done_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_done_q <= 16'd0;
      stat_err_q  <= 16'd0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_done = stat_done_q;
  assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_aec_sched.sv
// Directed self-checking bench for aec_sched (NREQ=4, MAX_LEN=16, TIMEOUT=10).
module tb_aec_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] aec_ascii;
  logic       aec_ready;
  logic       aec_valid;
  logic [6:0] aec_result;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_id;
  logic [6:0] resp_result;
  logic [1:0] resp_err;
  logic       busy;
`ifdef AEC_SCHED_STATS_EN
  logic [15:0] stat_done;
  logic [15:0] stat_err;
`endif

  int  checks = 0;
  int  fails  = 0;
  byte burst_buf [64];
  int  burst_n;

  aec_sched #(.NREQ(4), .IDW(2), .MAX_LEN(16), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
    .aec_ascii(aec_ascii), .aec_ready(aec_ready),
    .aec_valid(aec_valid), .aec_result(aec_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err),
    .busy(busy)
`ifdef AEC_SCHED_STATS_EN
    , .stat_done(stat_done), .stat_err(stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int cyc);
    cyc = 0;
    while (gnt === 4'b0000 && cyc < 20) begin
      tick();
      cyc++;
    end
    g = gnt;
    if (gnt === 4'b0000) begin
      checks++; fails++;
      $display("FAIL grant_wait: gnt still %b after %0d cycles", gnt, cyc);
    end
  endtask

  task automatic load_expr(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int w;
      w = 0;
      in_char  = s[i];
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (in_ready !== 1'b1) begin
        checks++; fails++;
        $display("FAIL load_wait: in_ready %b, required 1", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic collect_burst();
    burst_n = 0;
    while (aec_ready === 1'b1 && burst_n < 64) begin
      burst_buf[burst_n] = aec_ascii;
      burst_n++;
      tick();
    end
  endtask

  function automatic bit burst_is(input string s);
    if (burst_n != s.len()) return 1'b0;
    for (int i = 0; i < s.len(); i++)
      if (burst_buf[i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic aec_reply(input logic [6:0] r);
    aec_valid  = 1'b1;
    aec_result = r;
    tick();
    aec_valid  = 1'b0;
    aec_result = 7'd0;
  endtask

  task automatic take_resp(input int hold, output int lat, output logic [1:0] id,
                           output logic [6:0] res, output logic [1:0] err, output bit stable);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
    if (resp_valid !== 1'b1) begin
      checks++; fails++;
      $display("FAIL resp_wait: resp_valid %b after %0d cycles", resp_valid, lat);
    end
    id = resp_id; res = resp_result; err = resp_err; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_id !== id || resp_result !== res || resp_err !== err)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0; in_char = 8'h00; in_valid = 1'b0;
    aec_valid = 1'b0; aec_result = 7'd0; resp_ready = 1'b0;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b required 0000", gnt); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++; if ({aec_ready, aec_ascii} !== 9'd0) begin fails++; $display("FAIL reset_aec: got %b/%h required 0/00", aec_ready, aec_ascii); end
    checks++; if ({resp_valid, resp_id, resp_result, resp_err} !== 12'd0) begin fails++; $display("FAIL reset_resp: got v%b id%0d r%0d e%0d required all 0", resp_valid, resp_id, resp_result, resp_err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] g; int cyc, lat; logic [1:0] id, err; logic [6:0] res; bit st;
    req = 4'b0001;
    wait_grant(g, cyc);
    checks++; if (g !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b required 0001", g); end
    checks++; if (cyc != 2) begin fails++; $display("FAIL single_gnt_latency: got %0d required 2", cyc); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL single_load_state: busy %b in_ready %b required 1 1", busy, in_ready); end
    load_expr("3+4*2=");
    collect_burst();
    checks++; if (burst_n != 6) begin fails++; $display("FAIL single_burst_len: got %0d required 6", burst_n); end
    checks++; if (!burst_is("3+4*2=")) begin fails++; $display("FAIL single_burst_data: characters differ from 3+4*2="); end
    aec_reply(7'd11);
    take_resp(0, lat, id, res, err, st);
    checks++; if (lat != 0) begin fails++; $display("FAIL single_resp_latency: got %0d required 0", lat); end
    checks++; if (id !== 2'd0 || res !== 7'd11 || err !== 2'd0) begin fails++; $display("FAIL single_resp: got id%0d r%0d e%0d required id0 r11 e0", id, res, err); end
    req = 4'b0000;
    checks++; if (resp_valid !== 1'b0 || gnt !== 4'b0000) begin fails++; $display("FAIL single_after_hs: resp_valid %b gnt %b required 0 0000", resp_valid, gnt); end
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy %b required 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g, exp_g; int cyc, lat; logic [1:0] id, err, exp_id; logic [6:0] res; bit st;
    req = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      exp_g  = (t % 2 == 0) ? 4'b0010 : 4'b1000;
      exp_id = (t % 2 == 0) ? 2'd1 : 2'd3;
      wait_grant(g, cyc);
      checks++; if (g !== exp_g) begin fails++; $display("FAIL rr_gnt%0d: got %b required %b", t, g, exp_g); end
      load_expr("1+1=");
      collect_burst();
      checks++; if (burst_n != 4) begin fails++; $display("FAIL rr_burst%0d: got %0d required 4", t, burst_n); end
      aec_reply(7'd2);
      take_resp(0, lat, id, res, err, st);
      checks++; if (id !== exp_id || res !== 7'd2 || err !== 2'd0) begin fails++; $display("FAIL rr_resp%0d: got id%0d r%0d e%0d required id%0d r2 e0", t, id, res, err, exp_id); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_overflow();
    logic [3:0] g; int cyc, lat; logic [1:0] id, err; logic [6:0] res; bit st; string s;
    s = "";
    for (int i = 0; i < 17; i++) s = {s, "7"};
    req = 4'b0101;
    wait_grant(g, cyc);
    checks++; if (g !== 4'b0001) begin fails++; $display("FAIL ovf_gnt: got %b required 0001", g); end
    load_expr(s);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ovf_drain_ready: got %b required 1", in_ready); end
    load_expr("=");
    collect_burst();
    checks++; if (burst_n != 0) begin fails++; $display("FAIL ovf_no_burst: got %0d aec_ready cycles required 0", burst_n); end
    take_resp(0, lat, id, res, err, st);
    checks++; if (id !== 2'd0 || res !== 7'd0 || err !== 2'd1) begin fails++; $display("FAIL ovf_resp: got id%0d r%0d e%0d required id0 r0 e1", id, res, err); end
    wait_grant(g, cyc);
    checks++; if (g !== 4'b0100) begin fails++; $display("FAIL ovf_next_gnt: got %b required 0100", g); end
    load_expr("2*3=");
    collect_burst();
    aec_reply(7'd6);
    take_resp(0, lat, id, res, err, st);
    checks++; if (id !== 2'd2 || res !== 7'd6 || err !== 2'd0 || burst_n != 4) begin fails++; $display("FAIL ovf_next_resp: got id%0d r%0d e%0d n%0d required id2 r6 e0 n4", id, res, err, burst_n); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_max_len();
    logic [3:0] g; int cyc, lat; logic [1:0] id, err; logic [6:0] res; bit st;
    req = 4'b1000;
    wait_grant(g, cyc);
    checks++; if (g !== 4'b1000) begin fails++; $display("FAIL max_gnt: got %b required 1000", g); end
    load_expr("1+2+3+4+5+6+7+8=");
    collect_burst();
    checks++; if (burst_n != 16) begin fails++; $display("FAIL max_burst_len: got %0d required 16", burst_n); end
    checks++; if (!burst_is("1+2+3+4+5+6+7+8=")) begin fails++; $display("FAIL max_burst_data: characters differ from 1+2+3+4+5+6+7+8="); end
    aec_reply(7'd36);
    take_resp(0, lat, id, res, err, st);
    checks++; if (id !== 2'd3 || res !== 7'd36 || err !== 2'd0) begin fails++; $display("FAIL max_resp: got id%0d r%0d e%0d required id3 r36 e0", id, res, err); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] g; int cyc, lat; logic [1:0] id, err; logic [6:0] res; bit st;
    req = 4'b0001;
    wait_grant(g, cyc);
    aec_reply(7'd5);
    load_expr("9=");
    collect_burst();
    checks++; if (burst_n != 2) begin fails++; $display("FAIL to_burst_len: got %0d required 2", burst_n); end
    take_resp(3, lat, id, res, err, st);
    checks++; if (lat != 10) begin fails++; $display("FAIL to_latency: got %0d required 10", lat); end
    checks++; if (id !== 2'd0 || res !== 7'd0 || err !== 2'd2) begin fails++; $display("FAIL to_resp: got id%0d r%0d e%0d required id0 r0 e2", id, res, err); end
    checks++; if (st !== 1'b1) begin fails++; $display("FAIL to_resp_stable: got %b required 1", st); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] g; int cyc, lat; logic [1:0] id, err; logic [6:0] res; bit st;
    req = 4'b0010;
    wait_grant(g, cyc);
    checks++; if (g !== 4'b0010) begin fails++; $display("FAIL mid_gnt: got %b required 0010", g); end
    load_expr("1+2+3=");
    tick(); tick();
    checks++; if (aec_ready !== 1'b1 || aec_ascii !== 8'h32) begin fails++; $display("FAIL mid_third_char: got %b/%h required 1/32", aec_ready, aec_ascii); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0000 || aec_ready !== 1'b0 || busy !== 1'b0 || aec_ascii !== 8'h00) begin fails++; $display("FAIL mid_reset: gnt %b aec_ready %b busy %b ascii %h required 0000 0 0 00", gnt, aec_ready, busy, aec_ascii); end
    rst = 1'b1;
    req = 4'b1001;
    wait_grant(g, cyc);
    checks++; if (g !== 4'b0001 || cyc != 2) begin fails++; $display("FAIL mid_regrant: got %b after %0d required 0001 after 2", g, cyc); end
    load_expr("5=");
    collect_burst();
    aec_reply(7'd5);
    take_resp(0, lat, id, res, err, st);
    checks++; if (id !== 2'd0 || res !== 7'd5 || err !== 2'd0) begin fails++; $display("FAIL mid_resp: got id%0d r%0d e%0d required id0 r5 e0", id, res, err); end
    req = 4'b0000;
    tick(); tick();
`ifdef AEC_SCHED_STATS_EN
    checks++; if (stat_done !== 16'd1 || stat_err !== 16'd0) begin fails++; $display("FAIL stats: got done %0d err %0d required 1 0", stat_done, stat_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_max_len();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
